// File: rtl/mac_array_sequencer_pkg.sv
// Shared constants for the mac_tile array sequencer:
// tile instruction codes, array modes and FSM state encoding.
package mac_array_sequencer_pkg;

  localparam logic [1:0] INST_IDLE = 2'b00;
  localparam logic [1:0] INST_LOAD = 2'b01;
  localparam logic [1:0] INST_EXEC = 2'b10;

  localparam logic MODE_WS = 1'b0;
  localparam logic MODE_OS = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ARST  = 3'd1,
    ST_LOAD  = 3'd2,
    ST_GAP   = 3'd3,
    ST_EXEC  = 3'd4,
    ST_DRAIN = 3'd5,
    ST_DONE  = 3'd6
  } state_e;

endpackage

// File: rtl/mac_array_sequencer_inst_stagger.sv
// Row instruction skew: row 0 is the registered issued instruction,
// each further row is the previous row delayed by one cycle.
module mac_array_sequencer_inst_stagger #(
  parameter int ROW = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       inst_in,
  output logic [2*ROW-1:0] inst_row
);

  logic [2*ROW-1:0] sh_q;
  logic [2*ROW-1:0] sh_d;

  always_comb begin
    sh_d      = sh_q;
    sh_d[1:0] = inst_in;
    for (int r = 1; r < ROW; r++) begin
      sh_d[2*r +: 2] = sh_q[2*(r-1) +: 2];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sh_q <= '0;
    end else begin
      sh_q <= sh_d;
    end
  end

  assign inst_row = sh_q;

endmodule

// File: rtl/mac_array_sequencer.sv
// Job sequencer for the ROW x COL mac_tile array: array reset,
// kernel load, execute and drain phases with L0/OFIFO back-pressure.
module mac_array_sequencer
  import mac_array_sequencer_pkg::*;
#(
  parameter int ROW   = 8,
  parameter int COL   = 8,
  parameter int LEN_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             mode,
  input  logic [LEN_W-1:0] exe_len,
  input  logic             l0_empty,
  input  logic             ofifo_full,
  output logic             l0_rd,
  output logic [2*ROW-1:0] inst_row,
  output logic             mode_select,
  output logic             array_rst,
  output logic             busy,
  output logic             done
);

  localparam int DRN   = ROW + COL;
  localparam int DRN_W = $clog2(DRN + 1);

  localparam logic [LEN_W-1:0] COL_L    = LEN_W'(COL);
  localparam logic [DRN_W-1:0] DRN_LAST = DRN_W'(DRN - 1);

  state_e           state_q, state_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [DRN_W-1:0] drn_q, drn_d;
  logic             mode_q, mode_d;

  logic             stall;
  logic [LEN_W-1:0] cnt_inc;
  logic [1:0]       issue;

  assign stall   = l0_empty | ofifo_full;
  assign cnt_inc = cnt_q + LEN_W'(1);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    len_d     = len_q;
    drn_d     = drn_q;
    mode_d    = mode_q;
    issue     = INST_IDLE;
    l0_rd     = 1'b0;
    array_rst = 1'b0;
    done      = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          mode_d  = mode;
          len_d   = exe_len;
          cnt_d   = '0;
          drn_d   = '0;
          state_d = (mode == MODE_OS) ? ST_EXEC : ST_ARST;
        end
      end
      ST_ARST: begin
        array_rst = 1'b1;
        state_d   = ST_LOAD;
      end
      ST_LOAD: begin
        if (!stall) begin
          issue = INST_LOAD;
          l0_rd = 1'b1;
          cnt_d = cnt_inc;
          if (cnt_inc == COL_L) begin
            cnt_d   = '0;
            state_d = ST_GAP;
          end
        end
      end
      ST_GAP: begin
        state_d = ST_EXEC;
      end
      ST_EXEC: begin
        // zero-length jobs fall straight through to drain
        if (cnt_q == len_q) begin
          state_d = ST_DRAIN;
        end else if (!stall) begin
          issue = INST_EXEC;
          l0_rd = 1'b1;
          cnt_d = cnt_inc;
          if (cnt_inc == len_q) begin
            state_d = ST_DRAIN;
          end
        end
      end
      ST_DRAIN: begin
        drn_d = drn_q + DRN_W'(1);
        if (drn_q == DRN_LAST) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      len_q   <= '0;
      drn_q   <= '0;
      mode_q  <= MODE_WS;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      drn_q   <= drn_d;
      mode_q  <= mode_d;
    end
  end

  assign busy        = (state_q != ST_IDLE);
  assign mode_select = mode_q;

  mac_array_sequencer_inst_stagger #(
    .ROW (ROW)
  ) u_inst_stagger (
    .clk      (clk),
    .reset    (reset),
    .inst_in  (issue),
    .inst_row (inst_row)
  );

endmodule

// File: tb/tb_mac_array_sequencer.sv
// Directed bench for mac_array_sequencer: WS/OS jobs, back-pressure,
// zero-length job, start while busy and mid-job reset.
module tb_mac_array_sequencer;

  localparam int ROW   = 8;
  localparam int COL   = 8;
  localparam int LEN_W = 8;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             start = 1'b0;
  logic             mode = 1'b0;
  logic [LEN_W-1:0] exe_len = '0;
  logic             l0_empty = 1'b0;
  logic             ofifo_full = 1'b0;
  logic             l0_rd;
  logic [2*ROW-1:0] inst_row;
  logic             mode_select;
  logic             array_rst;
  logic             busy;
  logic             done;

  int total = 0;
  int bad = 0;

  logic [1:0] r0h [256];
  logic [1:0] r7h [256];
  logic       rdh [256];
  logic       arh [256];
  logic       msh [256];
  logic       byh [256];
  logic       dnh [256];
  logic [2*ROW-1:0] irh [256];

  int n_rd, n_ld, n_ex, n_ar, n_dn, n_by, n_ms;
  int done_k, last_ex_k, klen;
  bit tmo;

  always #5 clk = ~clk;

  mac_array_sequencer #(
    .ROW   (ROW),
    .COL   (COL),
    .LEN_W (LEN_W)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .mode        (mode),
    .exe_len     (exe_len),
    .l0_empty    (l0_empty),
    .ofifo_full  (ofifo_full),
    .l0_rd       (l0_rd),
    .inst_row    (inst_row),
    .mode_select (mode_select),
    .array_rst   (array_rst),
    .busy        (busy),
    .done        (done)
  );

  // job cycle k: start is presented at k=0; samples taken 1ns after negedge
  task automatic run_job(input logic m, input logic [LEN_W-1:0] len,
                         input int e_lo, input int e_hi,
                         input int f_lo, input int f_hi,
                         input int s2_at, input int rst_at,
                         input int budget);
    int k;
    n_rd = 0; n_ld = 0; n_ex = 0; n_ar = 0;
    n_dn = 0; n_by = 0; n_ms = 0;
    done_k = -1; last_ex_k = -1; tmo = 0;
    for (int i = 0; i < 256; i++) begin
      r0h[i] = '0; r7h[i] = '0; rdh[i] = 0; arh[i] = 0;
      msh[i] = 0; byh[i] = 0; dnh[i] = 0; irh[i] = '0;
    end
    k = 0;
    while (1) begin
      @(negedge clk);
      start      = (k == 0) || (k == s2_at);
      mode       = (k == 0) ? m : ~m;
      exe_len    = (k == 0) ? len : len + LEN_W'(5);
      l0_empty   = (k >= e_lo) && (k <= e_hi);
      ofifo_full = (k >= f_lo) && (k <= f_hi);
      reset      = (k == rst_at);
      #1;
      r0h[k] = inst_row[1:0];
      r7h[k] = inst_row[2*ROW-1 -: 2];
      rdh[k] = l0_rd; arh[k] = array_rst; msh[k] = mode_select;
      byh[k] = busy; dnh[k] = done; irh[k] = inst_row;
      n_rd += int'(l0_rd);
      n_ar += int'(array_rst);
      n_dn += int'(done);
      n_by += int'(busy);
      n_ms += int'(mode_select);
      if (inst_row[1:0] == 2'b01) n_ld++;
      if (inst_row[1:0] == 2'b10) begin
        n_ex++;
        last_ex_k = k;
      end
      if (done && done_k < 0) done_k = k;
      k++;
      if (done_k >= 0 && k > done_k + 4) break;
      if (k >= budget) begin
        tmo = (done_k < 0);
        break;
      end
    end
    klen = k;
    start = 0; reset = 0; l0_empty = 0; ofifo_full = 0;
  endtask

  task automatic test_reset();
    reset = 1;
    start = 1;
    mode = 1;
    repeat (3) @(negedge clk);
    #1;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%0b exp=0", busy); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL rst_done got=%0b exp=0", done); end
    total++; if (l0_rd !== 1'b0) begin bad++; $display("FAIL rst_l0_rd got=%0b exp=0", l0_rd); end
    total++; if (array_rst !== 1'b0) begin bad++; $display("FAIL rst_array_rst got=%0b exp=0", array_rst); end
    total++; if (mode_select !== 1'b0) begin bad++; $display("FAIL rst_mode_select got=%0b exp=0", mode_select); end
    total++; if (inst_row !== '0) begin bad++; $display("FAIL rst_inst_row got=%h exp=0", inst_row); end
    start = 0;
    mode = 0;
    reset = 0;
  endtask

  task automatic test_ws();
    int m7;
    run_job(1'b0, 8'd4, -1, -1, -1, -1, -1, -1, 200);
    m7 = 0;
    for (int k = 0; k < klen; k++) begin
      logic [1:0] e;
      e = (k >= ROW - 1) ? r0h[k-(ROW-1)] : 2'b00;
      if (r7h[k] !== e) m7++;
    end
    total++; if (tmo !== 0) begin bad++; $display("FAIL ws_timeout got=%0d exp=0", tmo); end
    total++; if (n_ar !== 1) begin bad++; $display("FAIL ws_arst_cnt got=%0d exp=1", n_ar); end
    total++; if (arh[1] !== 1'b1) begin bad++; $display("FAIL ws_arst_k1 got=%0b exp=1", arh[1]); end
    total++; if (n_ld !== 8) begin bad++; $display("FAIL ws_load_cnt got=%0d exp=8", n_ld); end
    total++; if (r0h[3] !== 2'b01) begin bad++; $display("FAIL ws_row0_k3 got=%b exp=01", r0h[3]); end
    total++; if (r0h[11] !== 2'b00) begin bad++; $display("FAIL ws_gap_k11 got=%b exp=00", r0h[11]); end
    total++; if (r0h[12] !== 2'b10) begin bad++; $display("FAIL ws_row0_k12 got=%b exp=10", r0h[12]); end
    total++; if (n_ex !== 4) begin bad++; $display("FAIL ws_exec_cnt got=%0d exp=4", n_ex); end
    total++; if (m7 !== 0) begin bad++; $display("FAIL ws_row7_skew got=%0d exp=0", m7); end
    total++; if (n_rd !== 12) begin bad++; $display("FAIL ws_l0_rd_cnt got=%0d exp=12", n_rd); end
    total++; if (done_k - last_ex_k !== 16) begin bad++; $display("FAIL ws_done_gap got=%0d exp=16", done_k - last_ex_k); end
    total++; if (n_by !== 31) begin bad++; $display("FAIL ws_busy_len got=%0d exp=31", n_by); end
    total++; if (n_dn !== 1) begin bad++; $display("FAIL ws_done_cnt got=%0d exp=1", n_dn); end
    total++; if (n_ms !== 0) begin bad++; $display("FAIL ws_mode_select got=%0d exp=0", n_ms); end
  endtask

  task automatic test_os();
    run_job(1'b1, 8'd3, -1, -1, -1, -1, -1, -1, 200);
    total++; if (tmo !== 0) begin bad++; $display("FAIL os_timeout got=%0d exp=0", tmo); end
    total++; if (n_ar !== 0) begin bad++; $display("FAIL os_arst_cnt got=%0d exp=0", n_ar); end
    total++; if (n_ld !== 0) begin bad++; $display("FAIL os_load_cnt got=%0d exp=0", n_ld); end
    total++; if (n_ex !== 3) begin bad++; $display("FAIL os_exec_cnt got=%0d exp=3", n_ex); end
    total++; if (msh[0] !== 1'b0) begin bad++; $display("FAIL os_ms_k0 got=%0b exp=0", msh[0]); end
    total++; if (msh[1] !== 1'b1) begin bad++; $display("FAIL os_ms_k1 got=%0b exp=1", msh[1]); end
    total++; if (n_rd !== 3) begin bad++; $display("FAIL os_l0_rd_cnt got=%0d exp=3", n_rd); end
    total++; if (done_k !== 20) begin bad++; $display("FAIL os_done_k got=%0d exp=20", done_k); end
    total++; if (n_dn !== 1) begin bad++; $display("FAIL os_done_cnt got=%0d exp=1", n_dn); end
  endtask

  task automatic test_backpressure();
    run_job(1'b0, 8'd4, 4, 5, 14, 16, -1, -1, 200);
    total++; if (tmo !== 0) begin bad++; $display("FAIL bp_timeout got=%0d exp=0", tmo); end
    total++; if (n_rd !== 12) begin bad++; $display("FAIL bp_l0_rd_cnt got=%0d exp=12", n_rd); end
    total++; if ({rdh[4], rdh[5]} !== 2'b00) begin bad++; $display("FAIL bp_rd_load_stall got=%b exp=00", {rdh[4], rdh[5]}); end
    total++; if ({rdh[3], rdh[6]} !== 2'b11) begin bad++; $display("FAIL bp_rd_load_edges got=%b exp=11", {rdh[3], rdh[6]}); end
    total++; if ({rdh[14], rdh[15], rdh[16]} !== 3'b000) begin bad++; $display("FAIL bp_rd_exec_stall got=%b exp=000", {rdh[14], rdh[15], rdh[16]}); end
    total++; if ({rdh[13], rdh[17]} !== 2'b11) begin bad++; $display("FAIL bp_rd_exec_edges got=%b exp=11", {rdh[13], rdh[17]}); end
    total++; if ({r0h[5], r0h[6]} !== 4'b0000) begin bad++; $display("FAIL bp_inst_load_stall got=%b exp=0000", {r0h[5], r0h[6]}); end
    total++; if ({r0h[15], r0h[16], r0h[17]} !== 6'b000000) begin bad++; $display("FAIL bp_inst_exec_stall got=%b exp=000000", {r0h[15], r0h[16], r0h[17]}); end
    total++; if ({r0h[14], r0h[18]} !== 4'b1010) begin bad++; $display("FAIL bp_inst_exec_edges got=%b exp=1010", {r0h[14], r0h[18]}); end
    total++; if (n_ld !== 8) begin bad++; $display("FAIL bp_load_cnt got=%0d exp=8", n_ld); end
    total++; if (n_ex !== 4) begin bad++; $display("FAIL bp_exec_cnt got=%0d exp=4", n_ex); end
    total++; if (n_by !== 36) begin bad++; $display("FAIL bp_busy_len got=%0d exp=36", n_by); end
    total++; if (done_k !== 36) begin bad++; $display("FAIL bp_done_k got=%0d exp=36", done_k); end
  endtask

  task automatic test_zero_len();
    run_job(1'b0, 8'd0, -1, -1, -1, -1, -1, -1, 200);
    total++; if (tmo !== 0) begin bad++; $display("FAIL zl_timeout got=%0d exp=0", tmo); end
    total++; if (n_ld !== 8) begin bad++; $display("FAIL zl_load_cnt got=%0d exp=8", n_ld); end
    total++; if (n_ex !== 0) begin bad++; $display("FAIL zl_exec_cnt got=%0d exp=0", n_ex); end
    total++; if (n_rd !== 8) begin bad++; $display("FAIL zl_l0_rd_cnt got=%0d exp=8", n_rd); end
    total++; if (n_by !== 28) begin bad++; $display("FAIL zl_busy_len got=%0d exp=28", n_by); end
    total++; if (done_k !== 28) begin bad++; $display("FAIL zl_done_k got=%0d exp=28", done_k); end
    total++; if (n_dn !== 1) begin bad++; $display("FAIL zl_done_cnt got=%0d exp=1", n_dn); end
  endtask

  task automatic test_start_ignored();
    run_job(1'b0, 8'd4, -1, -1, -1, -1, 12, -1, 200);
    total++; if (tmo !== 0) begin bad++; $display("FAIL si_timeout got=%0d exp=0", tmo); end
    total++; if (n_ex !== 4) begin bad++; $display("FAIL si_exec_cnt got=%0d exp=4", n_ex); end
    total++; if (n_rd !== 12) begin bad++; $display("FAIL si_l0_rd_cnt got=%0d exp=12", n_rd); end
    total++; if (n_dn !== 1) begin bad++; $display("FAIL si_done_cnt got=%0d exp=1", n_dn); end
    total++; if (n_ms !== 0) begin bad++; $display("FAIL si_mode_select got=%0d exp=0", n_ms); end
    total++; if (n_by !== 31) begin bad++; $display("FAIL si_busy_len got=%0d exp=31", n_by); end
  endtask

  task automatic test_abort();
    run_job(1'b0, 8'd4, -1, -1, -1, -1, -1, 13, 40);
    total++; if (byh[13] !== 1'b1) begin bad++; $display("FAIL ab_busy_before got=%0b exp=1", byh[13]); end
    total++; if (r0h[13] !== 2'b10) begin bad++; $display("FAIL ab_exec_before got=%b exp=10", r0h[13]); end
    total++; if ({byh[14], dnh[14], rdh[14], arh[14], msh[14]} !== 5'b00000) begin bad++; $display("FAIL ab_ctrl_after got=%b exp=00000", {byh[14], dnh[14], rdh[14], arh[14], msh[14]}); end
    total++; if (irh[14] !== '0) begin bad++; $display("FAIL ab_inst_after got=%h exp=0", irh[14]); end
    total++; if (n_dn !== 0) begin bad++; $display("FAIL ab_no_done got=%0d exp=0", n_dn); end
    total++; if (byh[39] !== 1'b0) begin bad++; $display("FAIL ab_idle_after got=%0b exp=0", byh[39]); end
    run_job(1'b0, 8'd4, -1, -1, -1, -1, -1, -1, 200);
    total++; if (tmo !== 0) begin bad++; $display("FAIL ab2_timeout got=%0d exp=0", tmo); end
    total++; if (n_ld !== 8) begin bad++; $display("FAIL ab2_load_cnt got=%0d exp=8", n_ld); end
    total++; if (n_ex !== 4) begin bad++; $display("FAIL ab2_exec_cnt got=%0d exp=4", n_ex); end
    total++; if (n_by !== 31) begin bad++; $display("FAIL ab2_busy_len got=%0d exp=31", n_by); end
    total++; if (done_k !== 31) begin bad++; $display("FAIL ab2_done_k got=%0d exp=31", done_k); end
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout got=stuck exp=finish");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_ws();
    test_os();
    test_backpressure();
    test_zero_len();
    test_start_ignored();
    test_abort();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
